// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master engine.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StGap
  } spi_state_e;

  // Mode encoding is {cpol, cpha}.
  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

  localparam int unsigned ByteEdges = 16;

endpackage

// File: rtl/spi_clk_tick.sv
// sck half-period divider: tick fires when the count reaches div_i, then wraps.
module spi_clk_tick #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_engine.sv
// Byte-oriented SPI master, all four CPOL/CPHA modes, MSB first, with a
// one-byte holding register so consecutive bytes share one ssn-low burst.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned GAP_HALF  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic                 tx_valid,
  input  logic [7:0]           tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 sck_o,
  output logic                 ssn_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam int unsigned     GapW     = (GAP_HALF > 1) ? $clog2(GAP_HALF) : 1;
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_HALF - 1);
  localparam logic [3:0]      LastEdge = 4'(ByteEdges - 1);

  spi_state_e           state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 sck_q, sck_d;
  logic                 ssn_q, ssn_d;
  logic                 mosi_q, mosi_d;
  logic [3:0]           edge_q, edge_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tick, tick_clr, consume, tx_load;

  assign tx_ready = ~hold_full_q;
  assign tx_load  = tx_valid & ~hold_full_q;
  assign busy     = (state_q != StIdle);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sck_o    = sck_q;
  assign ssn_o    = ssn_q;
  assign mosi_o   = mosi_q;

  // Every state starts its tick interval from zero.
  assign tick_clr = (state_d != state_q) || (state_q == StIdle);

  spi_clk_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tick_clr),
    .div_i (div_q),
    .tick_o(tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    ssn_d      = ssn_q;
    mosi_d     = mosi_q;
    edge_d     = edge_q;
    gap_d      = gap_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    consume    = 1'b0;

    unique case (state_q)
      StIdle: begin
        sck_d = cpol_i;
        if (hold_full_q) begin
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          div_d   = clk_div_i;
          shift_d = hold_q;
          mosi_d  = hold_q[7];
          ssn_d   = 1'b0;
          consume = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tick) begin
          edge_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + 4'd1;
          // Even edge index is leading; CPHA selects which parity samples.
          if (edge_q[0] == cpha_q) rx_shift_d = {rx_shift_q[6:0], miso_i};
          if (cpha_q ? !edge_q[0] : (edge_q[0] && (edge_q != LastEdge))) begin
            mosi_d  = cpha_q ? shift_q[7] : shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
          end
          if (edge_q == LastEdge) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_d;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        if (tick) begin
          if (hold_full_q) begin
            shift_d = hold_q;
            mosi_d  = hold_q[7];
            edge_d  = '0;
            consume = 1'b1;
            state_d = StXfer;
          end else begin
            ssn_d   = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (gap_q == GapLast) state_d = StIdle;
          else                  gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    hold_d      = tx_load ? tx_data : hold_q;
    hold_full_d = hold_full_q;
    if (consume) hold_full_d = 1'b0;
    if (tx_load) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sck_q       <= 1'b0;
      ssn_q       <= 1'b1;
      mosi_q      <= 1'b0;
      edge_q      <= '0;
      gap_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      sck_q       <= sck_d;
      ssn_q       <= ssn_d;
      mosi_q      <= mosi_d;
      edge_q      <= edge_d;
      gap_q       <= gap_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      div_q       <= div_d;
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench: table of single-byte transfers plus burst, backpressure and reset sequences.
module tb_spi_master_engine;
  import spi_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cpol_i, cpha_i;
  logic [7:0] clk_div_i;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, sck_o, ssn_o, mosi_o, miso_i;
  logic [7:0] rx_data;

  always #5 clk_i = ~clk_i;

  spi_master_engine dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cpol_i   (cpol_i),
    .cpha_i   (cpha_i),
    .clk_div_i(clk_div_i),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sck_o    (sck_o),
    .ssn_o    (ssn_o),
    .mosi_o   (mosi_o),
    .miso_i   (miso_i)
  );

  // Slave model state
  logic       loop_en, s_miso, cur_cpol, cur_cpha;
  logic [7:0] s_tx, s_rx;
  int         s_ptr, s_cnt;
  logic [7:0] s_got[$];
  logic [7:0] rx_got[$];
  int         rxv_cyc[$];
  int         cyc, ssn_low, sck_tog, ssn_falls, ssn_rises;
  logic       sck_at_fall, sck_at_rise, sck_prev, ssn_prev;
  int         n_checks, n_err;

  assign miso_i = loop_en ? mosi_o : s_miso;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] tx;
    logic       loop;
    logic [7:0] s_tx;
    logic [7:0] exp_rx;
    int         exp_low;
  } vec_t;

  vec_t vecs[8];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Slave: drives miso on its shift edges, captures mosi on its sample edges.
  initial begin
    logic lead;
    s_miso = 1'b0; s_ptr = 0; s_cnt = 0; s_rx = '0;
    sck_prev = 1'b0; ssn_prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        s_ptr = 0; s_cnt = 0; s_miso = 1'b0;
      end else begin
        if (ssn_prev && !ssn_o) begin
          ssn_falls++;
          sck_at_fall = sck_prev;
          if (!cur_cpha) begin
            s_miso = s_tx[3'(7 - (s_ptr % 8))];
            s_ptr++;
          end
        end
        if (!ssn_prev && ssn_o) begin
          ssn_rises++;
          sck_at_rise = sck_o;
        end
        if (!ssn_o) ssn_low++;
        if (!ssn_o && (sck_o != sck_prev)) begin
          sck_tog++;
          lead = (sck_o != cur_cpol);
          if (lead != cur_cpha) begin
            s_rx = {s_rx[6:0], mosi_o};
            s_cnt++;
            if (s_cnt == 8) begin
              s_got.push_back(s_rx);
              s_cnt = 0;
            end
          end else begin
            s_miso = s_tx[3'(7 - (s_ptr % 8))];
            s_ptr++;
          end
        end
        if (rx_valid) begin
          rx_got.push_back(rx_data);
          rxv_cyc.push_back(cyc);
        end
      end
      sck_prev = sck_o;
      ssn_prev = ssn_o;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    s_got.delete(); rx_got.delete(); rxv_cyc.delete();
    ssn_low = 0; sck_tog = 0; ssn_falls = 0; ssn_rises = 0;
    s_ptr = 0; s_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk_i);
    while (!tx_ready && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("send_ready_timeout", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk_i);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (!(!busy && tx_ready) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_timeout", 32'(!busy && tx_ready), 32'd1);
  endtask

  task automatic set_mode(input logic [1:0] m, input logic [7:0] d, input logic lp,
                          input logic [7:0] stx);
    @(posedge clk_i);
    #1;
    cpol_i = m[1]; cpha_i = m[0]; cur_cpol = m[1]; cur_cpha = m[0];
    clk_div_i = d; loop_en = lp; s_tx = stx;
    repeat (3) @(posedge clk_i);
    #1 clear_mon();
  endtask

  function automatic logic [31:0] q_at(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hdead;
  endfunction

  initial begin
    int n;
    int acc_cyc;
    n_checks = 0; n_err = 0;
    rst_i = 1'b1; tx_valid = 1'b0; tx_data = '0;
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = '0;
    loop_en = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0; s_tx = '0;
    clear_mon();

    vecs[0] = '{Mode0, 8'd7, 8'hA5, 1'b0, 8'h3C, 8'h3C, 144};
    vecs[1] = '{Mode1, 8'd3, 8'h81, 1'b1, 8'h00, 8'h81, 72};
    vecs[2] = '{Mode2, 8'd3, 8'h81, 1'b1, 8'h00, 8'h81, 72};
    vecs[3] = '{Mode3, 8'd3, 8'h81, 1'b1, 8'h00, 8'h81, 72};
    vecs[4] = '{Mode0, 8'd0, 8'hFF, 1'b1, 8'h00, 8'hFF, 18};
    vecs[5] = '{Mode0, 8'd0, 8'h00, 1'b1, 8'h00, 8'h00, 18};
    vecs[6] = '{Mode3, 8'd1, 8'h5C, 1'b0, 8'h96, 8'h96, 36};
    vecs[7] = '{Mode2, 8'd2, 8'hC3, 1'b0, 8'h6B, 8'h6B, 54};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_sck", 32'(sck_o), 0);
    check("rst_ssn", 32'(ssn_o), 1);
    check("rst_mosi", 32'(mosi_o), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_mode(vecs[i].mode, vecs[i].div, vecs[i].loop, vecs[i].s_tx);
      send(vecs[i].tx);
      wait_idle();
      check($sformatf("v%0d rx_count", i), rx_got.size(), 1);
      check($sformatf("v%0d rx_data", i), q_at(rx_got, 0), 32'(vecs[i].exp_rx));
      check($sformatf("v%0d slave_mosi", i), q_at(s_got, 0), 32'(vecs[i].tx));
      check($sformatf("v%0d ssn_low", i), ssn_low, vecs[i].exp_low);
      check($sformatf("v%0d sck_toggles", i), sck_tog, 16);
      check($sformatf("v%0d ssn_falls", i), ssn_falls, 1);
      check($sformatf("v%0d sck_idle_pre", i), 32'(sck_at_fall), 32'(vecs[i].mode[1]));
      check($sformatf("v%0d sck_idle_post", i), 32'(sck_at_rise), 32'(vecs[i].mode[1]));
    end

    // Burst of 16 bytes with tx_valid held high.
    set_mode(Mode0, 8'd1, 1'b1, 8'h00);
    begin
      int idx = 1;
      n = 0;
      tx_valid = 1'b1;
      tx_data  = 8'd1;
      while (idx <= 16 && n < 3000) begin
        @(negedge clk_i);
        n++;
        if (tx_ready) begin
          @(posedge clk_i);
          #1;
          idx++;
          if (idx <= 16) tx_data = 8'(idx);
          else           tx_valid = 1'b0;
        end
      end
      tx_valid = 1'b0;
      check("burst_feed_timeout", idx, 17);
    end
    wait_idle();
    check("burst_rx_count", rx_got.size(), 16);
    check("burst_slave_count", s_got.size(), 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("burst_slave_b%0d", k), q_at(s_got, k), k + 1);
      check($sformatf("burst_rx_b%0d", k), q_at(rx_got, k), k + 1);
    end
    for (int k = 1; k < 16; k++) begin
      check($sformatf("burst_spacing_%0d", k),
            (k < rxv_cyc.size()) ? rxv_cyc[k] - rxv_cyc[k-1] : -1, 34);
    end
    check("burst_ssn_falls", ssn_falls, 1);
    check("burst_ssn_rises", ssn_rises, 1);
    check("burst_ssn_low", ssn_low, 546);

    // Backpressure: third byte offered while the holding register is full.
    set_mode(Mode0, 8'd3, 1'b1, 8'h00);
    send(8'h11);
    send(8'h22);
    n = 0;
    while (sck_tog < 3 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("bp_ready_low", 32'(tx_ready), 0);
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    n = 0;
    acc_cyc = -1;
    while (n < 500) begin
      @(negedge clk_i);
      n++;
      if (tx_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk_i);
    #1 tx_valid = 1'b0;
    check("bp_accept_cycle", (rxv_cyc.size() > 0) ? acc_cyc - rxv_cyc[0] : -1, 4);
    wait_idle();
    check("bp_rx_count", rx_got.size(), 3);
    check("bp_rx_b0", q_at(rx_got, 0), 32'h11);
    check("bp_rx_b1", q_at(rx_got, 1), 32'h22);
    check("bp_rx_b2", q_at(rx_got, 2), 32'h33);
    check("bp_ssn_falls", ssn_falls, 1);

    // Reset mid-byte with a second byte waiting in the holding register.
    set_mode(Mode0, 8'd3, 1'b1, 8'h00);
    send(8'hC7);
    send(8'h99);
    n = 0;
    while (sck_tog < 9 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_rst_reached", sck_tog, 9);
    rst_i = 1'b1;
    #1;
    check("mid_rst_sck", 32'(sck_o), 0);
    check("mid_rst_ssn", 32'(ssn_o), 1);
    check("mid_rst_mosi", 32'(mosi_o), 0);
    check("mid_rst_tx_ready", 32'(tx_ready), 1);
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_mon();
    repeat (40) @(negedge clk_i);
    check("post_rst_no_rx", rx_got.size(), 0);
    check("post_rst_no_ssn", ssn_falls, 0);
    send(8'h5A);
    wait_idle();
    check("post_rst_rx_count", rx_got.size(), 1);
    check("post_rst_rx", q_at(rx_got, 0), 32'h5A);
    check("post_rst_slave", q_at(s_got, 0), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
